// File: rtl/dmem_pkg.sv
// Purpose: shared types and constants for the data-memory responder slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

  // Responder FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LATENCY_MAX = 15;
  localparam int WORD_BYTES  = 4;
  localparam int BYTE_OFF_W  = $clog2(WORD_BYTES);
  // Wide enough to hold LATENCY_MAX-1, the largest value the wait counter loads.
  localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

  // True when a byte address does not point at the first byte of a word.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[BYTE_OFF_W-1:0] != '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Purpose: single-port 32-bit word RAM, synchronous write, combinational read.
// Latency: write commits at the clock edge where we is high; rdata follows idx.
// Backpressure: none; the responder FSM decides when an access happens.
// Ports: clk; we (write enable); idx (word index); wdata (write word);
//        rdata (word currently addressed by idx).
// INIT_FILE: accepted for interface compatibility; contents are never cleared by reset.
module dmem_array #(
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Purpose: M-stage data-memory responder; one load/store outstanding at a time.
// Latency: accept edge in cycle T -> rsp_valid pulse in cycle T+LATENCY (1..15).
// Backpressure: req_ready only in IDLE; stall holds the pipeline until RESP.
// Ports: clk, rst (async, active high); req_valid/req_we/req_addr/req_wdata from
//        the M stage; req_ready; rsp_valid (1-cycle pulse); rsp_rdata (load data,
//        0 for stores, held until the next access); stall to the hazard unit.
// Build option DMEM_ALIGN_CHECK_EN: adds rsp_err; a misaligned request still
//        takes LATENCY cycles but writes nothing and returns 0 with rsp_err=1.
// ADDR_W must be at most 29 so the word index fits below req_addr[31].
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    LATENCY   = 2,
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic        rsp_err,
`endif
  output logic        stall
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                mis_q, mis_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                access;
  logic                ram_we;
  logic [31:0]         ram_rdata;
  logic [ADDR_W-1:0]   req_idx;
  logic                req_mis;
  logic                unused_addr_bits;

  // Upper address bits wrap; byte offset only matters with the alignment check.
  assign req_idx          = req_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis = is_misaligned(req_addr);
`else
  assign req_mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    access  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          idx_d   = req_idx;
          mis_d   = req_mis;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // Any request offered now is ignored; the requester re-presents it.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The *_d copies always describe the access being performed: on a
    // LATENCY==1 accept they are the live request, in WAIT they equal *_q.
    if (access) begin
      rdata_d = (we_d || mis_d) ? 32'h0 : ram_rdata;
    end
  end

  assign ram_we = access && we_d && !mis_d;

  dmem_array #(
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .idx  (idx_d),
    .wdata(wdata_d),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q, err_d;

  // Set on the access edge, so it is high exactly in the RESP cycle.
  always_comb begin
    err_d = access ? mis_d : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q;
`endif

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  // Released in RESP so the pipeline advances while load data is valid.
  assign stall     = ((state_q == IDLE) && req_valid) || (state_q == WAIT);

endmodule
